// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: shares one registered write port
// among NREQ requesters, with locked bursts and a lock timeout. Define WB_ARB_RR_EN for round-robin.
module rf_wb_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int LOCK_TMO = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic               we,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata,
    output logic [1:0]         owner,
    output logic               locked
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_owner, w_owner_nxt;
    logic [7:0]      r_tmo, w_tmo_nxt;
    logic            w_any;
    logic [1:0]      w_gnt;
    logic            w_acc;
    logic [1:0]      w_sel;
    logic [NREQ-1:0] w_ready;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic            w_wr;
    logic            r_we_p1;
    logic [AW-1:0]   r_waddr_p1;
    logic [DW-1:0]   r_wdata_p1;

`ifdef WB_ARB_RR_EN
    logic [1:0]      r_ptr, w_ptr_nxt;

    // Lowest offset from the pointer wins, so scan offsets from high to low.
    always_comb begin
        w_any = 1'b0;
        w_gnt = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_gnt = 2'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (r_state == ST_IDLE && w_any)
            w_ptr_nxt = 2'((int'(w_gnt) + 1) % NREQ);
        else if (r_state == ST_LOCKED && w_state_nxt == ST_IDLE)
            w_ptr_nxt = 2'((int'(r_owner) + 1) % NREQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= 2'd0;
        else
            r_ptr <= w_ptr_nxt;
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_gnt = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_any = 1'b1;
                w_gnt = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_tmo_nxt   = r_tmo;
        w_ready     = '0;
        w_acc       = 1'b0;
        w_sel       = w_gnt;
        if (r_state == ST_IDLE) begin
            if (w_any) begin
                w_ready[w_gnt] = 1'b1;
                w_acc          = 1'b1;
                w_owner_nxt    = w_gnt;
                w_tmo_nxt      = 8'd0;
                if (req_lock[w_gnt])
                    w_state_nxt = ST_LOCKED;
            end
        end else begin
            w_sel = r_owner;
            if (req_valid[r_owner]) begin
                w_ready[r_owner] = 1'b1;
                w_acc            = 1'b1;
                w_tmo_nxt        = 8'd0;
                if (!req_lock[r_owner])
                    w_state_nxt = ST_IDLE;
            end else if (r_tmo == 8'(LOCK_TMO - 1)) begin
                // Owner went quiet too long: force the port open again.
                w_state_nxt = ST_IDLE;
                w_tmo_nxt   = 8'd0;
            end else begin
                w_tmo_nxt = r_tmo + 8'd1;
            end
        end
    end

    assign w_sel_addr = req_waddr[int'(w_sel)*AW +: AW];
    assign w_sel_data = req_wdata[int'(w_sel)*DW +: DW];
    // Beats to r0 are accepted but never reach the write port.
    assign w_wr       = w_acc && (w_sel_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_tmo   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // Stage p1: registered write toward the regfile port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
        end else begin
            r_we_p1 <= w_wr;
            if (w_wr) begin
                r_waddr_p1 <= w_sel_addr;
                r_wdata_p1 <= w_sel_data;
            end
        end
    end

    assign req_ready = rst ? '0 : w_ready;
    assign we        = r_we_p1;
    assign waddr     = r_waddr_p1;
    assign wdata     = r_wdata_p1;
    assign owner     = r_owner;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: single write, contention, locked burst,
// lock timeout, r0 write and asynchronous reset mid-burst.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_lock  = '0;
    logic [14:0] req_waddr = '0;
    logic [95:0] req_wdata = '0;
    logic [2:0]  req_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  owner;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int exp_g;

    rf_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .LOCK_TMO(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_lock[i]         = l;
        req_waddr[i*5 +: 5]   = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        req_valid = '0;
        req_lock  = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset state, including ready held low during reset
        set_req(0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        rst = 1'b0;
        #1;
        chk("single_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF);
        #1;
        chk("single_we", 32'(we), 32'h1);
        chk("single_waddr", 32'(waddr), 32'd5);
        chk("single_wdata", wdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("single_we_off", 32'(we), 32'h0);
        chk("single_waddr_hold", 32'(waddr), 32'd5);

        // Contention, no lock
        rst_pulse();
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h11);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h22);
        set_req(2, 1'b1, 1'b0, 5'd3, 32'h33);
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
            exp_g = i % 3;
`else
            exp_g = 0;
`endif
            chk("cont_ready", 32'(req_ready), 32'(1 << exp_g));
            @(negedge clk); #1;
            chk("cont_we", 32'(we), 32'h1);
            chk("cont_waddr", 32'(waddr), 32'(exp_g + 1));
        end

        // Locked burst from req1 while req0 waits
        rst_pulse();
        set_req(1, 1'b1, 1'b1, 5'd8, 32'h88);
        #1;
        chk("burst_rdy_a", 32'(req_ready), 32'b010);
        chk("burst_lock_a", 32'(locked), 32'h0);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 5'd9, 32'h99);
        set_req(0, 1'b1, 1'b0, 5'd3, 32'h30);
        #1;
        chk("burst_rdy_b", 32'(req_ready), 32'b010);
        chk("burst_lock_b", 32'(locked), 32'h1);
        chk("burst_owner_b", 32'(owner), 32'h1);
        chk("burst_waddr_b", 32'(waddr), 32'd8);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 5'd9, 32'h99);
        #1;
        chk("burst_rdy_c", 32'(req_ready), 32'b001);
        chk("burst_lock_c", 32'(locked), 32'h0);
        chk("burst_we_c", 32'(we), 32'h1);
        chk("burst_waddr_c", 32'(waddr), 32'd9);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'd3, 32'h30);
        #1;
        chk("burst_we_d", 32'(we), 32'h1);
        chk("burst_waddr_d", 32'(waddr), 32'd3);
        chk("burst_wdata_d", wdata, 32'h30);
        chk("burst_owner_d", 32'(owner), 32'h0);

        // Lock timeout: req2 locks then goes silent
        rst_pulse();
        set_req(2, 1'b1, 1'b1, 5'd10, 32'hA);
        #1;
        chk("tmo_rdy_grant", 32'(req_ready), 32'b100);
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 5'd10, 32'hA);
        set_req(0, 1'b1, 1'b0, 5'd4, 32'h44);
        #1;
        for (int i = 1; i <= 15; i++) begin
            chk("tmo_rdy_wait", 32'(req_ready), 32'b000);
            chk("tmo_locked", 32'(locked), 32'h1);
            chk("tmo_we", 32'(we), 32'(i == 1));
            @(negedge clk); #1;
        end
        chk("tmo_rdy_release", 32'(req_ready), 32'b001);
        chk("tmo_unlocked", 32'(locked), 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'd4, 32'h44);
        #1;
        chk("tmo_we_after", 32'(we), 32'h1);
        chk("tmo_waddr_after", 32'(waddr), 32'd4);

        // r0 write is accepted but suppressed
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 5'd7, 32'h77);
        #1;
        chk("r0_pre_rdy", 32'(req_ready), 32'b010);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 5'd7, 32'h77);
        set_req(0, 1'b1, 1'b0, 5'd0, 32'h1234);
        #1;
        chk("r0_rdy", 32'(req_ready), 32'b001);
        chk("r0_pre_owner", 32'(owner), 32'h1);
        chk("r0_pre_we", 32'(we), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h1234);
        #1;
        chk("r0_we", 32'(we), 32'h0);
        chk("r0_owner", 32'(owner), 32'h0);
        chk("r0_waddr_hold", 32'(waddr), 32'd7);

        // Asynchronous reset while a locked beat is pending
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 5'd12, 32'hC);
        #1;
        chk("ar_rdy_a", 32'(req_ready), 32'b100);
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 5'd13, 32'hD);
        #1;
        chk("ar_locked_b", 32'(locked), 32'h1);
        chk("ar_owner_b", 32'(owner), 32'h2);
        @(posedge clk); #1;
        chk("ar_pending_we", 32'(we), 32'h1);
        chk("ar_pending_waddr", 32'(waddr), 32'd13);
        rst = 1'b1;
        #1;
        chk("ar_we", 32'(we), 32'h0);
        chk("ar_locked", 32'(locked), 32'h0);
        chk("ar_owner", 32'(owner), 32'h0);
        chk("ar_ready", 32'(req_ready), 32'b000);
        set_req(2, 1'b0, 1'b0, 5'd13, 32'hD);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("ar_we_next", 32'(we), 32'h0);
        @(negedge clk); #1;
        chk("ar_we_next2", 32'(we), 32'h0);
        chk("ar_waddr_next2", 32'(waddr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
